// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// mem_stage: memory-access pipeline stage between EXE and WB with response buffering and flush absorb.
// Optional load-wait performance counter enabled by defining MEM_PERF_CNT_EN.
module mem_stage #(
  parameter int BUS_W = 70
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_exe_to_mem_valid,
  output logic             o_mem_allow_in,
  input  logic [31:0]      i_exe_pc,
  input  logic [31:0]      i_exe_inst,
  input  logic [31:0]      i_exe_result,
  input  logic             i_exe_gr_we,
  input  logic             i_exe_res_from_mem,
  input  logic             i_exe_mem_we,
  input  logic             i_exe_ls_cancel,
  input  logic             i_exe_ex,
  input  logic [4:0]       i_exe_dest,
  input  logic             i_data_sram_data_ok,
  input  logic [31:0]      i_data_sram_rdata,
  input  logic             i_wb_ex,
  input  logic             i_ertn_flush,
  output logic             o_mem_to_wb_valid,
  input  logic             i_wb_allow_in,
  output logic [BUS_W-1:0] o_mem_to_wb_bus,
  output logic [38:0]      o_mem_wr_bus,
  output logic [31:0]      o_perf_ld_wait
);

  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_op_e;

  localparam int FULL_W = 71;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [9:0]  r_op;
  logic [31:0] r_result;
  logic        r_gr_we;
  logic        r_res_from_mem;
  logic        r_mem_we;
  logic        r_ls_cancel;
  logic        r_ex;
  logic [4:0]  r_dest;
  logic        r_resp_got;
  logic [31:0] r_rdata_buf;
  logic        r_drop_pend;
  logic        r_flush_seen;

  logic              w_flush;
  logic              w_wait_resp;
  logic              w_ready_go;
  logic              w_allow_in;
  logic              w_accept;
  logic              w_load_pending;
  ld_op_e            w_ld_op;
  logic [31:0]       w_raw;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld_val;
  logic [31:0]       w_final;
  logic [FULL_W-1:0] w_bus_full;
  logic              w_unused;

  assign w_flush        = i_wb_ex | i_ertn_flush;
  assign w_wait_resp    = r_valid & (r_res_from_mem | r_mem_we) & ~r_ls_cancel;
  assign w_ready_go     = ~w_wait_resp | r_resp_got | i_data_sram_data_ok;
  assign w_allow_in     = (~r_valid | (w_ready_go & i_wb_allow_in)) & ~r_drop_pend;
  assign w_accept       = i_exe_to_mem_valid & w_allow_in;
  assign w_load_pending = r_valid & r_res_from_mem & ~w_ready_go;
  assign w_unused       = ^i_exe_inst[21:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid        <= 1'b0;
      r_pc           <= 32'd0;
      r_op           <= 10'd0;
      r_result       <= 32'd0;
      r_gr_we        <= 1'b0;
      r_res_from_mem <= 1'b0;
      r_mem_we       <= 1'b0;
      r_ls_cancel    <= 1'b0;
      r_ex           <= 1'b0;
      r_dest         <= 5'd0;
    end else begin
      if (w_allow_in)
        r_valid <= i_exe_to_mem_valid;
      if (w_accept) begin
        r_pc           <= i_exe_pc;
        r_op           <= i_exe_inst[31:22];
        r_result       <= i_exe_result;
        r_gr_we        <= i_exe_gr_we;
        r_res_from_mem <= i_exe_res_from_mem;
        r_mem_we       <= i_exe_mem_we;
        r_ls_cancel    <= i_exe_ls_cancel;
        r_ex           <= i_exe_ex;
        r_dest         <= i_exe_dest;
      end
    end
  end

  // The buffer only takes the first response of an entry, so stalled data stays stable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_resp_got  <= 1'b0;
      r_rdata_buf <= 32'd0;
    end else begin
      if (w_allow_in)
        r_resp_got <= 1'b0;
      else if (w_wait_resp & i_data_sram_data_ok)
        r_resp_got <= 1'b1;
      if (w_wait_resp & i_data_sram_data_ok & ~r_resp_got)
        r_rdata_buf <= i_data_sram_rdata;
    end
  end

  // A flush with the response still outstanding must hold the stage until that response drains.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_drop_pend  <= 1'b0;
      r_flush_seen <= 1'b0;
    end else begin
      if (r_drop_pend) begin
        if (i_data_sram_data_ok)
          r_drop_pend <= 1'b0;
      end else if (w_flush & w_wait_resp & ~r_resp_got & ~i_data_sram_data_ok) begin
        r_drop_pend <= 1'b1;
      end
      if (w_flush)
        r_flush_seen <= 1'b1;
      else if (w_accept)
        r_flush_seen <= 1'b0;
    end
  end

  always_comb begin
    case (r_op)
      10'h0A0: w_ld_op = LD_B;
      10'h0A1: w_ld_op = LD_H;
      10'h0A8: w_ld_op = LD_BU;
      10'h0A9: w_ld_op = LD_HU;
      default: w_ld_op = LD_W;
    endcase
  end

  always_comb begin
    w_raw = r_resp_got ? r_rdata_buf : i_data_sram_rdata;
    case (r_result[1:0])
      2'd0:    w_byte = w_raw[7:0];
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
    w_half = r_result[1] ? w_raw[31:16] : w_raw[15:0];
    case (w_ld_op)
      LD_B:    w_ld_val = {{24{w_byte[7]}}, w_byte};
      LD_BU:   w_ld_val = {24'd0, w_byte};
      LD_H:    w_ld_val = {{16{w_half[15]}}, w_half};
      LD_HU:   w_ld_val = {16'd0, w_half};
      default: w_ld_val = w_raw;
    endcase
    w_final = r_res_from_mem ? w_ld_val : r_result;
  end

  // Fields pack from the LSB up; a BUS_W narrower than 71 drops the top field (ex) first.
  assign w_bus_full        = {r_ex, r_gr_we, r_dest, w_final, r_pc};
  assign o_mem_to_wb_bus   = BUS_W'(w_bus_full);
  assign o_mem_allow_in    = w_allow_in;
  assign o_mem_to_wb_valid = r_valid & w_ready_go & ~r_flush_seen;
  assign o_mem_wr_bus      = {r_valid & r_gr_we, w_load_pending, r_dest, w_final};

`ifdef MEM_PERF_CNT_EN
  logic [31:0] r_perf_ld_wait;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_perf_ld_wait <= 32'd0;
    else if (w_load_pending)
      r_perf_ld_wait <= r_perf_ld_wait + 32'd1;
  end

  assign o_perf_ld_wait = r_perf_ld_wait;
`else
  assign o_perf_ld_wait = 32'd0;
`endif

endmodule
